// File: rtl/control_buffer_pixeles.sv
// Fetch controller for a 2x4 pixel buffer: issues one word read at a time while a whole
// group is free, counts unconsumed pixels, and ends a frame only once the buffer is empty.
module control_buffer_pixeles #(
  parameter int ADDR_BITS  = 32,
  parameter int COUNT_BITS = 20,
  parameter int WORD_BYTES = 4
)(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_BITS-1:0]  base_addr,
  input  logic [COUNT_BITS-1:0] total_words,
  output logic                  mem_req,
  output logic [ADDR_BITS-1:0]  mem_addr,
  input  logic                  mem_ack,
  input  logic                  mem_data_valid,
  output logic                  save_mem_data,
  output logic                  read_pixel,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DRAIN} state_t;

  state_t                state, state_nx;
  logic [3:0]            fill, fill_nx;
  logic [COUNT_BITS-1:0] words_left, words_left_nx;
  logic [ADDR_BITS-1:0]  addr, addr_nx;
  logic                  done_nx;

  assign pix_valid     = (fill != 4'd0);
  assign read_pixel    = pix_valid & pix_ready;
  assign save_mem_data = mem_data_valid & (state == WAIT);
  assign mem_req       = (state == REQ);
  assign busy          = (state != IDLE);
  assign mem_addr      = addr;

  // A save and a read in the same cycle net to +3.
  always_comb begin
    fill_nx = fill;
    if (save_mem_data) fill_nx = fill_nx + 4'd4;
    if (read_pixel)    fill_nx = fill_nx - 4'd1;
  end

  always_comb begin
    state_nx      = state;
    addr_nx       = addr;
    words_left_nx = words_left;
    done_nx       = 1'b0;
    case (state)
      IDLE: if (start) begin
        if (total_words != '0) begin
          state_nx      = REQ;
          addr_nx       = base_addr;
          words_left_nx = total_words;
        end else begin
          done_nx = 1'b1;
        end
      end
      REQ: if (mem_ack) begin
        state_nx = WAIT;
        addr_nx  = addr + ADDR_BITS'(WORD_BYTES);
      end
      WAIT: if (mem_data_valid) begin
        words_left_nx = words_left - COUNT_BITS'(1);
        if (words_left == COUNT_BITS'(1)) state_nx = DRAIN;
        else if (fill_nx <= 4'd4)         state_nx = REQ;
        else                              state_nx = HOLD;
      end
      HOLD: if (fill <= 4'd4) state_nx = REQ;
      // Leaving only on an empty buffer keeps group/read pointers aligned for the next frame.
      DRAIN: if (fill == 4'd0) begin
        state_nx = IDLE;
        done_nx  = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      fill       <= 4'd0;
      words_left <= '0;
      addr       <= '0;
      done       <= 1'b0;
    end else begin
      state      <= state_nx;
      fill       <= fill_nx;
      words_left <= words_left_nx;
      addr       <= addr_nx;
      done       <= done_nx;
    end
  end

endmodule

// File: tb/tb_control_buffer_pixeles.sv
// Randomized scoreboard bench: stimulus queues expected addresses and per-frame pixel counts,
// a negedge monitor tracks buffer occupancy abstractly and checks every DUT output.
module tb_control_buffer_pixeles;
  localparam int AB = 32;
  localparam int CB = 20;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [AB-1:0] base_addr;
  logic [CB-1:0] total_words;
  logic          mem_req, mem_ack, mem_data_valid;
  logic [AB-1:0] mem_addr;
  logic          save_mem_data, read_pixel, pix_valid, pix_ready, busy, done;

  int checks = 0, errors = 0;

  control_buffer_pixeles #(.ADDR_BITS(AB), .COUNT_BITS(CB), .WORD_BYTES(4)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .total_words(total_words),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data_valid(mem_data_valid),
    .save_mem_data(save_mem_data), .read_pixel(read_pixel), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // scoreboard state
  logic [AB-1:0] addr_q[$];
  int            done_q[$];
  int            m_fill = 0, frame_reads = 0, done_cnt = 0, save_cnt = 0;
  bit            outstanding = 0, prev_pend = 0, e_read, e_save;
  logic [AB-1:0] prev_addr;

  // stimulus knobs
  int ready_mode = 0, ack_dly = 0, dv_min = 0, dv_max = 0;
  bit force_dv = 0;
  int resp_st = 0, resp_cnt = 0;

  initial begin
    pix_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       pix_ready = 1'b0;
        1:       pix_ready = 1'b1;
        default: pix_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // memory: ack after ack_dly cycles of mem_req, data dv_min..dv_max cycles after the ack cycle
  initial begin
    mem_ack = 1'b0; mem_data_valid = 1'b0;
    forever begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      mem_data_valid = force_dv;
      if (reset) begin
        resp_st = 0; resp_cnt = 0;
      end else if (resp_st == 0) begin
        if (mem_req) begin
          if (resp_cnt >= ack_dly) begin
            mem_ack = 1'b1; resp_st = 1; resp_cnt = int'($urandom_range(dv_min, dv_max));
          end else resp_cnt++;
        end
      end else begin
        if (resp_cnt == 0) begin mem_data_valid = 1'b1; resp_st = 0; end
        else resp_cnt--;
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      m_fill = 0; outstanding = 0; frame_reads = 0; prev_pend = 0;
      addr_q.delete(); done_q.delete();
    end else begin
      e_read = (m_fill != 0) && pix_ready;
      e_save = mem_data_valid && outstanding;
      chk("pix_valid", pix_valid, m_fill != 0);
      chk("read_pixel", read_pixel, e_read);
      chk("save_mem_data", save_mem_data, e_save);
      if (prev_pend) begin
        chk("req_hold", mem_req, 1);
        chk("addr_hold", mem_addr, prev_addr);
      end
      if (mem_req) begin
        chk("req_gate", (m_fill <= 4) && !outstanding, 1);
        chk("busy_req", busy, 1);
        if (mem_ack) begin
          if (addr_q.size() == 0) chk("addr_unexpected", addr_q.size(), 1);
          else chk("mem_addr", mem_addr, addr_q.pop_front());
          outstanding = 1;
        end
      end
      prev_pend = mem_req && !mem_ack;
      prev_addr = mem_addr;
      if (done) begin
        done_cnt++;
        chk("done_busy", busy, 0);
        chk("done_fill", m_fill, 0);
        if (done_q.size() == 0) chk("done_unexpected", done_q.size(), 1);
        else chk("frame_pixels", frame_reads, done_q.pop_front());
        frame_reads = 0;
      end
      if (e_save) begin outstanding = 0; save_cnt++; end
      if (e_read) frame_reads++;
      m_fill = m_fill + (e_save ? 4 : 0) - (e_read ? 1 : 0);
      chk("fill_range", (m_fill >= 0) && (m_fill <= 8), 1);
    end
  end

  task automatic do_start(input logic [AB-1:0] b, input int n);
    @(posedge clk); #1;
    base_addr = b; total_words = CB'(n); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("req_latency", mem_req, n != 0);
  endtask

  task automatic push_frame(input logic [AB-1:0] b, input int n);
    for (int i = 0; i < n; i++) addr_q.push_back(b + AB'(4 * i));
    done_q.push_back(4 * n);
  endtask

  task automatic wait_done(input int d0);
    int t = 0;
    while (done_cnt == d0 && t < 3000) begin @(posedge clk); t++; end
    chk("done_timeout", done_cnt > d0, 1);
  endtask

  task automatic frame(input logic [AB-1:0] b, input int n);
    int d0;
    push_frame(b, n);
    d0 = done_cnt;
    do_start(b, n);
    wait_done(d0);
  endtask

  initial begin
    int d0, s0, k;
    logic [AB-1:0] b;
    reset = 1'b0; start = 1'b0; base_addr = '0; total_words = '0;
    #1 reset = 1'b1;
    #11;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_save", save_mem_data, 0);
    chk("rst_read", read_pixel, 0);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(posedge clk); #2 reset = 1'b0;

    // single word, steady consumer
    ready_mode = 1; ack_dly = 1; dv_min = 0; dv_max = 0;
    frame(32'h100, 1);
    chk("single_busy_end", busy, 0);

    // zero-length frame
    d0 = done_cnt;
    done_q.push_back(0);
    do_start(32'h500, 0);
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    @(posedge clk); #1;
    chk("zero_done_pulse", done, 0);
    chk("zero_no_req", mem_req, 0);

    // stalled consumer: buffer fills to two groups, third request waits for a free group
    ready_mode = 0; ack_dly = 0;
    push_frame(32'h2000, 3);
    d0 = done_cnt; s0 = save_cnt;
    do_start(32'h2000, 3);
    repeat (30) @(posedge clk);
    #1;
    chk("stall_saves", save_cnt - s0, 2);
    chk("stall_no_req", mem_req, 0);
    chk("stall_valid", pix_valid, 1);
    chk("stall_busy", busy, 1);
    @(negedge clk); ready_mode = 1;
    k = 0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (mem_req) begin k = i; break; end
    end
    chk("third_req_cycle", k, 6);
    wait_done(d0);

    // slow ack with start pulsed mid-frame
    ack_dly = 5;
    push_frame(32'h3000, 2);
    d0 = done_cnt;
    do_start(32'h3000, 2);
    repeat (2) @(posedge clk);
    #1 base_addr = 32'h9000; total_words = CB'(7); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(d0);
    repeat (3) @(posedge clk);
    #1;
    chk("after_frame_busy", busy, 0);
    chk("after_frame_req", mem_req, 0);

    // randomized frames
    ready_mode = 2; dv_min = 0; dv_max = 3;
    for (int f = 0; f < 8; f++) begin
      ack_dly = int'($urandom_range(0, 3));
      b = AB'($urandom_range(0, 32'hFFFF)) << 2;
      frame(b, (f == 0) ? 16 : int'($urandom_range(1, 12)));
    end

    // reset while waiting for data
    ready_mode = 1; ack_dly = 0; dv_min = 5; dv_max = 5;
    push_frame(32'h4000, 4);
    d0 = done_cnt;
    do_start(32'h4000, 4);
    k = 0;
    for (int i = 0; i < 20; i++) begin
      if (mem_ack) begin k = 1; break; end
      @(posedge clk); #1;
    end
    chk("reset_test_ack_seen", k, 1);
    @(posedge clk); #3 reset = 1'b1;
    #1;
    chk("midrst_mem_req", mem_req, 0);
    chk("midrst_mem_addr", mem_addr, 0);
    chk("midrst_pix_valid", pix_valid, 0);
    chk("midrst_read", read_pixel, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    @(posedge clk); #2 reset = 1'b0;
    @(negedge clk); force_dv = 1'b1;
    @(posedge clk); #2;
    chk("late_dv_driven", mem_data_valid, 1);
    chk("late_dv_ignored", save_mem_data, 0);
    force_dv = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("reset_no_done", done_cnt, d0);
    chk("reset_idle", busy, 0);

    // recovery after abandoned frame
    dv_min = 0; dv_max = 2; ready_mode = 2;
    frame(32'h6000, 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/control_buffer_pixeles.md
CONTROL_BUFFER_PIXELES -- requirements
Module: control_buffer_pixeles

Interface
REQ-001 Parameter ADDR_BITS, 32: memory address width.
REQ-002 Parameter COUNT_BITS, 20: width of word counter and total_words.
REQ-003 Parameter WORD_BYTES, 4: address increment per fetched memory word (4 pixels per word).
REQ-004 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  one-cycle pulse; begins a frame fetch.
REQ-008 base_addr  input  ADDR_BITS  first word address; sampled on accepted start.
REQ-009 total_words  input  COUNT_BITS  number of words to fetch; sampled on accepted start.
REQ-010 mem_req  output  1  memory read request; held until mem_ack.
REQ-011 mem_addr  output  ADDR_BITS  read address; stable while mem_req=1.
REQ-012 mem_ack  input  1  memory accepted the current request.
REQ-013 mem_data_valid  input  1  read data valid on the pixel buffer data bus this cycle.
REQ-014 save_mem_data  output  1  write strobe to the pixel buffer (drives its save_mem_data).
REQ-015 read_pixel  output  1  advance strobe to the pixel buffer (drives its read_pixel).
REQ-016 pix_valid  output  1  pixel buffer output holds an unconsumed pixel.
REQ-017 pix_ready  input  1  consumer takes the pixel this cycle.
REQ-018 busy  output  1  frame in progress.
REQ-019 done  output  1  one-cycle pulse at frame end.

Function
REQ-020 The block SHALL keep a registered fill counter (0..8, 4 bits) of unconsumed pixels in the two-group (2x4) pixel buffer.
REQ-021 pix_valid SHALL equal (fill != 0); read_pixel SHALL equal pix_valid AND pix_ready (combinational).
REQ-022 save_mem_data SHALL equal mem_data_valid AND state==WAIT (combinational); mem_data_valid in any other state SHALL be ignored.
REQ-023 Fill update per cycle: +4 on save_mem_data, -1 on read_pixel; both in the same cycle SHALL give +3.
REQ-024 At most one request SHALL be outstanding; a new request SHALL issue only when fill <= 4 (a whole free group exists).
REQ-025 FSM states: IDLE, REQ, WAIT, HOLD, DRAIN; mem_req = (state==REQ), busy = (state!=IDLE).
REQ-026 IDLE: start with total_words!=0 -> REQ, load addr=base_addr, words_left=total_words; start with total_words==0 -> stay IDLE, done=1 next cycle.
REQ-027 REQ: on mem_ack -> WAIT, addr <= addr + WORD_BYTES; without mem_ack mem_req and mem_addr SHALL hold.
REQ-028 WAIT: on mem_data_valid, words_left -1; if words_left was 1 -> DRAIN; else if updated fill <= 4 -> REQ; else -> HOLD.
REQ-029 HOLD: when fill <= 4 -> REQ.
REQ-030 DRAIN: when fill == 0 -> IDLE with done=1 for exactly that transition cycle (registered, visible the cycle after fill reaches 0).
REQ-031 start outside IDLE SHALL be ignored.
REQ-032 Latency: start at cycle N -> mem_req=1 at cycle N+1; save at cycle M -> pix_valid=1 at cycle M+1.
REQ-033 The frame SHALL end only with fill==0, keeping the buffer group and read pointers aligned for the next frame.

Reset
REQ-034 reset=1 SHALL immediately force state IDLE, fill=0, words_left=0, addr=0, done=0; hence mem_req, mem_addr, save_mem_data, read_pixel, pix_valid, busy, done all 0.
REQ-035 Reset mid-frame SHALL abandon the frame without done; any later mem_data_valid SHALL be ignored.

Verification
REQ-036 total_words=1, base_addr=0x100, ack 1 cycle after req, data 0xAABBCCDD next cycle, pix_ready=1 -> mem_addr=0x100, one save, read_pixel 4 consecutive cycles (AA,BB,CC,DD), done one pulse, busy low.
REQ-037 total_words=3, pix_ready=0 -> two saves, fill=8, no third mem_req; then pix_ready=1 -> third mem_req the cycle after fill reaches 4, addr=base+8.
REQ-038 fill=1, pix_ready=1 with save in same cycle -> fill=4 next cycle; no underflow/overflow across a 16-word frame with random pix_ready.
REQ-039 start with total_words=0 -> done pulse next cycle, mem_req never asserted, busy stays 0.
REQ-040 mem_ack delayed 5 cycles -> mem_req and mem_addr stable all 5 cycles; start pulsed while busy -> ignored.
REQ-041 reset asserted in WAIT -> all outputs 0 before the next clock edge; subsequent mem_data_valid -> save_mem_data stays 0.
